conv_encoder_packer: RTL and testbench
======================================

CONV_ENCODER_PACKER -- requirements
Module: conv_encoder_packer

Interface
REQ-001 Parameter G0, default 3'b111, generator polynomial for the first coded bit of each pair (bit 2 = current input bit).
REQ-002 Parameter G1, default 3'b101, generator polynomial for the second coded bit of each pair (same bit ordering).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 bit_in  input  1  information bit to encode.
REQ-006 bit_valid  input  1  bit_in is valid this cycle.
REQ-007 bit_ready  output  1  block accepts bit_in this cycle.
REQ-008 term  input  1  terminate trellis after the current or next accepted bit; level-sampled only while bit_ready=1.
REQ-009 data_out  output  16  packed coded word; pair k occupies bits [15-2k:14-2k], so pair 0 is in [15:14].
REQ-010 out_valid  output  1  data_out holds a complete word.
REQ-011 out_ready  input  1  downstream consumes data_out this cycle.
REQ-012 out_last  output  1  word contains the final tail pair of a terminated block; qualified by out_valid.

Function
REQ-013 Encoder state SHALL be two bits {s1,s0}: s1 = previous encoded bit, s0 = the bit before it.
REQ-014 For encoded bit b, the pair SHALL be {c0,c1}: c0 = XOR of G0-selected bits of {b,s1,s0}, c1 = likewise with G1; then {s1,s0} <= {b,s1}.
REQ-015 FSM states SHALL be ACCEPT, TAIL, PAD, HOLD; reset state is ACCEPT.
REQ-016 bit_ready SHALL be 1 only in ACCEPT; a bit is consumed when bit_valid=1 and bit_ready=1.
REQ-017 In ACCEPT, each consumed bit SHALL be encoded in that cycle and its pair written into the slot given by pair_cnt (0..7), and pair_cnt SHALL increment.
REQ-018 A term=1 sampled in ACCEPT SHALL set a tail-pending flag; if a bit is consumed in the same cycle, that bit is encoded before the tail.
REQ-019 In ACCEPT with term=1 and bit_valid=0, the block SHALL enter TAIL next cycle, with no bit consumed.
REQ-020 TAIL SHALL encode one 0 bit per cycle, two in total (tail_cnt 0..1), each written like a data pair; after the second, tail-pending clears and encoder state is 2'b00.
REQ-021 After the last tail pair, if pair_cnt != 0 the block SHALL enter PAD, writing 2'b00 into one slot per cycle without changing encoder state until slot 7 is written; if pair_cnt = 0 it SHALL go to HOLD (word complete) or ACCEPT.
REQ-022 Whenever slot 7 is written (data, tail or pad), the FSM SHALL enter HOLD next cycle and pair_cnt SHALL wrap to 0.
REQ-023 In HOLD, out_valid=1; data_out and out_last SHALL remain stable until out_ready=1.
REQ-024 On HOLD with out_ready=1, the FSM SHALL leave HOLD next cycle: to TAIL if tail bits remain, else ACCEPT; out_valid drops to 0 in that cycle.
REQ-025 out_last SHALL be 1 for exactly the word into which the second tail pair was written, including when the tail straddles two words.
REQ-026 A terminated block never emits an empty (all-pad, zero-data) word.
REQ-027 out_valid=0 outside HOLD; data_out SHALL change only while out_valid=0.
REQ-028 Word latency: last contributing pair written in cycle N -> out_valid=1 in cycle N+1.
REQ-029 term while not in ACCEPT SHALL be ignored.

Reset
REQ-030 rst=1 at a clock edge SHALL, in any state including mid-TAIL/PAD/HOLD, force: FSM=ACCEPT, {s1,s0}=00, pair_cnt=0, tail_cnt=0, tail-pending=0, data_out=16'h0000, out_valid=0, out_last=0; bit_ready=1 from the cycle after rst deasserts.
REQ-031 A word in progress or held at reset SHALL be discarded, not emitted.

Verification
REQ-032 Bits 1,0,1,1,0,0,0,0 from reset, out_ready=1 -> data_out=16'hE170, out_valid for 1 cycle, out_last=0, bit_ready=0 in that cycle.
REQ-033 Bits 1,1 with term=1 alongside the second bit -> 2 TAIL cycles, 4 PAD cycles, then data_out=16'hD700, out_last=1, encoder state 00.
REQ-034 Seven 0 bits then bit 1 with term=1 -> first word 16'h0003, out_last=0; after handshake, TAIL resumes -> second word 16'hB000, out_last=1.
REQ-035 Hold out_ready=0 for 10 cycles after a word completes -> out_valid, data_out, out_last constant; bit_ready=0; no bits consumed.
REQ-036 rst=1 during PAD -> next cycle all outputs at reset values; subsequent bits 1,0,1,1,0,0,0,0 again yield 16'hE170.
REQ-037 term=1 with bit_valid=0 immediately after a word handshake (pair_cnt=0) -> tail pairs in slots 0-1 (continuing from current state), 6 PAD pairs, out_last=1.

Source files
------------

// File: rtl/conv_encoder_packer.sv
// Rate-1/2 K=3 convolutional encoder with trellis termination.
// Coded pairs are packed eight to a 16-bit word behind a valid/ready handshake.
module conv_encoder_packer #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  input  logic        term,
  output logic [15:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  typedef enum logic [1:0] {
    ACCEPT,
    TAIL,
    PAD,
    HOLD
  } state_t;

  state_t      st;
  logic [1:0]  enc_st;
  logic [2:0]  pair_cnt;
  logic        tail_cnt;
  logic        tail_pend;

  logic        enc_b;
  logic [2:0]  taps;
  logic [1:0]  pair;
  logic [3:0]  slot_hi;
  logic        last_slot;

  assign bit_ready = (st == ACCEPT);
  assign out_valid = (st == HOLD);
  assign last_slot = (pair_cnt == 3'd7);
  assign slot_hi   = 4'd15 - {pair_cnt, 1'b0};

  // Coded pair for the bit entering the trellis (tail bits are zero).
  always_comb begin
    enc_b = 1'b0;
    if (st == ACCEPT) enc_b = bit_in;
    taps = {enc_b, enc_st};
    pair = {^(G0 & taps), ^(G1 & taps)};
  end

  // Block FSM: accept data, flush tail, pad the word, hold for downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ACCEPT;
      enc_st    <= 2'b00;
      pair_cnt  <= 3'd0;
      tail_cnt  <= 1'b0;
      tail_pend <= 1'b0;
      data_out  <= 16'h0000;
      out_last  <= 1'b0;
    end else begin
      unique case (st)
        ACCEPT: begin
          if (term) tail_pend <= 1'b1;
          if (bit_valid) begin
            data_out[slot_hi -: 2] <= pair;
            enc_st   <= {bit_in, enc_st[1]};
            pair_cnt <= pair_cnt + 3'd1;
            if (last_slot) begin
              st       <= HOLD;
              out_last <= 1'b0;
            end else if (term) begin
              st <= TAIL;
            end
          end else if (term) begin
            st <= TAIL;
          end
        end
        TAIL: begin
          data_out[slot_hi -: 2] <= pair;
          enc_st   <= {1'b0, enc_st[1]};
          pair_cnt <= pair_cnt + 3'd1;
          if (tail_cnt) begin
            tail_cnt  <= 1'b0;
            tail_pend <= 1'b0;
          end else begin
            tail_cnt <= 1'b1;
          end
          if (last_slot) begin
            st       <= HOLD;
            out_last <= tail_cnt;
          end else if (tail_cnt) begin
            st <= PAD;
          end
        end
        PAD: begin
          data_out[slot_hi -: 2] <= 2'b00;
          pair_cnt <= pair_cnt + 3'd1;
          if (last_slot) begin
            st       <= HOLD;
            out_last <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            st       <= tail_pend ? TAIL : ACCEPT;
            out_last <= 1'b0;
          end
        end
        default: st <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_packer.sv
// Directed bench for conv_encoder_packer.
// Expected words are hand-derived from the G0=111 / G1=101 trellis.
module tb_conv_encoder_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        term;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int errors = 0;
  int checks = 0;
  int n;

  conv_encoder_packer dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .term      (term),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic t);
    int w = 0;
    while (!bit_ready && w < 100) begin
      step();
      w++;
    end
    chk("send_ready", {15'd0, bit_ready}, 16'd1);
    bit_in    = b;
    bit_valid = 1'b1;
    term      = t;
    step();
    bit_valid = 1'b0;
    term      = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic wait_word(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      step();
      cyc++;
    end
    chk("word_timeout", {15'd0, out_valid}, 16'd1);
  endtask

  task automatic send_e170();
    send(1, 0); send(0, 0); send(1, 0); send(1, 0);
    send(0, 0); send(0, 0); send(0, 0); send(0, 0);
  endtask

  initial begin
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    term      = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_data", data_out, 16'h0000);
    chk("rst_last", {15'd0, out_last}, 16'd0);
    chk("rst_ready", {15'd0, bit_ready}, 16'd1);

    // Plain word, immediate handshake
    send_e170();
    chk("w1_valid", {15'd0, out_valid}, 16'd1);
    chk("w1_data", data_out, 16'hE170);
    chk("w1_last", {15'd0, out_last}, 16'd0);
    chk("w1_ready", {15'd0, bit_ready}, 16'd0);
    step();
    chk("w1_drop", {15'd0, out_valid}, 16'd0);
    chk("w1_accept", {15'd0, bit_ready}, 16'd1);

    // Short block: tail plus four pad pairs, then backpressure
    out_ready = 1'b0;
    send(1, 0);
    send(1, 1);
    chk("w2_tail_rdy", {15'd0, bit_ready}, 16'd0);
    wait_word(n);
    chk("w2_cycles", n[15:0], 16'd6);
    chk("w2_data", data_out, 16'hD700);
    chk("w2_last", {15'd0, out_last}, 16'd1);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", {15'd0, out_valid}, 16'd1);
      chk("hold_data", data_out, 16'hD700);
      chk("hold_last", {15'd0, out_last}, 16'd1);
      chk("hold_ready", {15'd0, bit_ready}, 16'd0);
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    out_ready = 1'b1;
    step();
    chk("w2_drop", {15'd0, out_valid}, 16'd0);

    // Tail straddles two words
    for (int i = 0; i < 7; i++) send(0, 0);
    send(1, 1);
    chk("w3_valid", {15'd0, out_valid}, 16'd1);
    chk("w3_data", data_out, 16'h0003);
    chk("w3_last", {15'd0, out_last}, 16'd0);
    step();
    chk("w3_drop", {15'd0, out_valid}, 16'd0);
    chk("w3_tail_rdy", {15'd0, bit_ready}, 16'd0);
    wait_word(n);
    chk("w4_cycles", n[15:0], 16'd8);
    chk("w4_data", data_out, 16'hB000);
    chk("w4_last", {15'd0, out_last}, 16'd1);
    step();

    // Term alone at a word boundary, encoder state carried over
    for (int i = 0; i < 7; i++) send(0, 0);
    send(1, 0);
    chk("w5_data", data_out, 16'h0003);
    chk("w5_last", {15'd0, out_last}, 16'd0);
    step();
    chk("w5_accept", {15'd0, bit_ready}, 16'd1);
    term = 1'b1;
    step();
    term = 1'b0;
    chk("w6_tail_rdy", {15'd0, bit_ready}, 16'd0);
    wait_word(n);
    chk("w6_cycles", n[15:0], 16'd8);
    chk("w6_data", data_out, 16'hB000);
    chk("w6_last", {15'd0, out_last}, 16'd1);
    step();

    // Reset during PAD discards the partial word
    send(1, 0);
    send(1, 1);
    step();
    step();
    chk("pad_valid", {15'd0, out_valid}, 16'd0);
    chk("pad_ready", {15'd0, bit_ready}, 16'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_valid", {15'd0, out_valid}, 16'd0);
    chk("rst2_data", data_out, 16'h0000);
    chk("rst2_last", {15'd0, out_last}, 16'd0);
    chk("rst2_ready", {15'd0, bit_ready}, 16'd1);
    send_e170();
    chk("w7_data", data_out, 16'hE170);
    chk("w7_last", {15'd0, out_last}, 16'd0);
    step();
    chk("w7_drop", {15'd0, out_valid}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
